// File: rtl/gtx_rx_align_pkg.sv
`default_nettype none
// ============================================================================
// Package   : gtx_pkg
// Purpose   : Shared types and constants for the GTX receive byte aligner.
//             Holds the alignment FSM state encoding, the K28.5 comma byte
//             and the width of the errored-word counter.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package gtx_pkg;

  // Alignment FSM states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // K28.5 comma byte as seen on rxdata when rxcharisk is set.
  localparam logic [7:0] K28_5 = 8'hBC;

  // Width of the saturating errored-word counter.
  localparam int ERR_CNT_W = 16;

endpackage : gtx_pkg
`default_nettype wire

// File: rtl/gtx_rx_align_if.sv
`default_nettype none
// ============================================================================
// Interface : gtx_rx_align_if
// Purpose   : Bundles the transceiver receive word and the aligned word
//             presented downstream.
// Signals   : rx_ctrl/rx_data/rx_disperr/rx_notintable - raw transceiver word
//             al_ctrl/al_data/al_valid/al_locked        - aligned word + status
//             al_err_cnt                                 - errored-word count
// Modports  : master - transceiver side (drives rx_*, observes al_*)
//             slave  - aligner side (consumes rx_*, drives al_*)
// Revision  : 1.0 - initial release
// ============================================================================
interface gtx_rx_align_if;
  import gtx_pkg::*;

  logic [1:0]           rx_ctrl;
  logic [15:0]          rx_data;
  logic [1:0]           rx_disperr;
  logic [1:0]           rx_notintable;
  logic [1:0]           al_ctrl;
  logic [15:0]          al_data;
  logic                 al_valid;
  logic                 al_locked;
  logic [ERR_CNT_W-1:0] al_err_cnt;

  modport master (
    output rx_ctrl, rx_data, rx_disperr, rx_notintable,
    input  al_ctrl, al_data, al_valid, al_locked, al_err_cnt
  );

  modport slave (
    input  rx_ctrl, rx_data, rx_disperr, rx_notintable,
    output al_ctrl, al_data, al_valid, al_locked, al_err_cnt
  );

endinterface : gtx_rx_align_if
`default_nettype wire

// File: rtl/gtx_rx_align.sv
`default_nettype none
// ============================================================================
// Module    : gtx_rx_align
// Purpose   : Comma-based byte aligner for a 2-byte GTX receive path. Hunts
//             for K28.5 in either byte lane, verifies LOCK_CNT consecutive
//             same-lane commas, then forwards byte-realigned words. Lock is
//             dropped after LOSS_CNT consecutive bad words.
// Ports     : clk_i          - rxusrclk2, single clock
//             rst_n_i        - synchronous active-low reset
//             ctrl_i[1:0]    - rxcharisk, bit n qualifies byte n
//             data_i[15:0]   - rxdata
//             disperr_i[1:0] - per-byte disparity error
//             notintable_i   - per-byte not-in-table error
//             ctrl_o/data_o  - aligned word (zero while not locked)
//             valid_o        - aligned word valid (lock held)
//             locked_o       - FSM is in LOCKED
//             err_cnt_o      - saturating errored-word count while locked
// Config    : GTX_RX_ALIGN_ERR_CNT_EN - when defined, err_cnt_o counts;
//             otherwise err_cnt_o is tied to zero.
// Revision  : 1.0 - initial release
// ============================================================================
module gtx_rx_align
  import gtx_pkg::*;
#(
  parameter logic [7:0] COMMA    = K28_5,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 4
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_n_i,
  input  wire logic [1:0]           ctrl_i,
  input  wire logic [15:0]          data_i,
  input  wire logic [1:0]           disperr_i,
  input  wire logic [1:0]           notintable_i,
  output logic      [1:0]           ctrl_o,
  output logic      [15:0]          data_o,
  output logic                      valid_o,
  output logic                      locked_o,
  output logic      [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_CNT_C = 4'(LOSS_CNT);

  state_e      state_q, state_d;
  logic        offset_q, offset_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic [15:0] prev_data_q;
  logic [1:0]  prev_ctrl_q;
  logic [15:0] data_q;
  logic [1:0]  ctrl_q;
  logic        valid_q;

  logic        hit_lo;
  logic        hit_hi;
  logic        hit;
  logic        hit_off;
  logic        word_err;
  logic        wrong_comma;
  logic [15:0] align_data;
  logic [1:0]  align_ctrl;

  assign hit_lo      = ctrl_i[0] && (data_i[7:0]  == COMMA);
  assign hit_hi      = ctrl_i[1] && (data_i[15:8] == COMMA);
  assign hit         = hit_lo || hit_hi;
  // A comma in both lanes resolves to the low lane.
  assign hit_off     = !hit_lo;
  assign word_err    = |{disperr_i, notintable_i};
  assign wrong_comma = hit && (hit_off != offset_q);

  // ---------------------------------------------------------------------------
  // Alignment FSM: next state / counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    good_d   = good_q;
    bad_d    = bad_q;
    unique case (state_q)
      HUNT: begin
        good_d = 4'd0;
        bad_d  = 4'd0;
        if (hit) begin
          offset_d = hit_off;
          good_d   = 4'd1;
          state_d  = (LOCK_CNT_C == 4'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (word_err || wrong_comma) begin
          good_d  = 4'd0;
          state_d = HUNT;
        end else if (hit) begin
          good_d = good_q + 4'd1;
          if ((good_q + 4'd1) >= LOCK_CNT_C) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (word_err || wrong_comma) begin
          bad_d = bad_q + 4'd1;
          // Loss is declared in the same cycle the limit is reached.
          if ((bad_q + 4'd1) >= LOSS_CNT_C) begin
            bad_d   = 4'd0;
            good_d  = 4'd0;
            state_d = HUNT;
          end
        end else begin
          bad_d = 4'd0;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte realignment. offset_d is used so the word captured on the lock edge
  // already uses the lane just latched (relevant when LOCK_CNT == 1).
  // Offset 1 takes the low byte of this word as the new high byte and the
  // high byte of the previous word as the new low byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    align_data = data_i;
    align_ctrl = ctrl_i;
    if (offset_d) begin
      align_data = {data_i[7:0], prev_data_q[15:8]};
      align_ctrl = {ctrl_i[0], prev_ctrl_q[1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= HUNT;
      offset_q    <= 1'b0;
      good_q      <= 4'd0;
      bad_q       <= 4'd0;
      prev_data_q <= 16'h0000;
      prev_ctrl_q <= 2'b00;
      data_q      <= 16'h0000;
      ctrl_q      <= 2'b00;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      prev_data_q <= data_i;
      prev_ctrl_q <= ctrl_i;
      // Output word and valid follow the state being entered so that
      // valid_o, locked_o and data_o change on the same edge.
      if (state_d == LOCKED) begin
        data_q  <= align_data;
        ctrl_q  <= align_ctrl;
        valid_q <= 1'b1;
      end else begin
        data_q  <= 16'h0000;
        ctrl_q  <= 2'b00;
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign valid_o  = valid_q;
  assign locked_o = (state_q == LOCKED);

  // ---------------------------------------------------------------------------
  // Errored-word counter (optional)
  // ---------------------------------------------------------------------------
`ifdef GTX_RX_ALIGN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
    end else if ((state_q == LOCKED) && word_err &&
                 (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule : gtx_rx_align
`default_nettype wire

// File: tb/tb_gtx_rx_align.sv
`default_nettype none
// ============================================================================
// Module    : tb_gtx_rx_align
// Purpose   : Self-checking bench for gtx_rx_align. A table of directed
//             words with hand-computed outputs is applied one word per
//             clock, followed by long error-injection sequences.
// Config    : GTX_RX_ALIGN_ERR_CNT_EN selects the expected err_cnt_o values
//             and enables the saturation run on a LOSS_CNT=15 instance.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_gtx_rx_align;
  import gtx_pkg::*;

  logic clk;
  logic rst_n;

  gtx_rx_align_if u_if ();

  gtx_rx_align u_dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ctrl_i       (u_if.rx_ctrl),
    .data_i       (u_if.rx_data),
    .disperr_i    (u_if.rx_disperr),
    .notintable_i (u_if.rx_notintable),
    .ctrl_o       (u_if.al_ctrl),
    .data_o       (u_if.al_data),
    .valid_o      (u_if.al_valid),
    .locked_o     (u_if.al_locked),
    .err_cnt_o    (u_if.al_err_cnt)
  );

`ifdef GTX_RX_ALIGN_ERR_CNT_EN
  // Tolerant instance: allows 14 errors between clean words so the
  // counter can be driven to saturation while lock is held.
  logic [1:0]  sat_ctrl;
  logic [15:0] sat_data;
  logic        sat_valid;
  logic        sat_locked;
  logic [15:0] sat_err;

  gtx_rx_align #(.LOSS_CNT(15)) u_dut_sat (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ctrl_i       (u_if.rx_ctrl),
    .data_i       (u_if.rx_data),
    .disperr_i    (u_if.rx_disperr),
    .notintable_i (u_if.rx_notintable),
    .ctrl_o       (sat_ctrl),
    .data_o       (sat_data),
    .valid_o      (sat_valid),
    .locked_o     (sat_locked),
    .err_cnt_o    (sat_err)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [1:0]  de;
    logic [1:0]  nit;
    logic        lk;
    logic [1:0]  co;
    logic [15:0] dout;
    logic [15:0] err;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] c,
                              input logic [15:0] d, input logic [1:0] de,
                              input logic [1:0] nit, input logic lk,
                              input logic [1:0] co, input logic [15:0] dout,
                              input logic [15:0] err);
    vec_t v;
    v.rst_n = r;  v.ctrl = c;  v.data = d;  v.de = de;  v.nit = nit;
    v.lk = lk;    v.co = co;   v.dout = dout; v.err = err;
    return v;
  endfunction

  // Expected err_cnt_o depends on whether the counter is built.
  function automatic logic [15:0] exp_err(input logic [15:0] v);
`ifdef GTX_RX_ALIGN_ERR_CNT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic drive(input logic r, input logic [1:0] c, input logic [15:0] d,
                       input logic [1:0] de, input logic [1:0] nit);
    @(negedge clk);
    rst_n                = r;
    u_if.rx_ctrl         = c;
    u_if.rx_data         = d;
    u_if.rx_disperr      = de;
    u_if.rx_notintable   = nit;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lk/vl=%b%b ctrl=%b data=%h err=%h, want lk/vl=%b%b ctrl=%b data=%h err=%h",
               name, act[35], act[34], act[33:32], act[31:16], act[15:0],
               exp[35], exp[34], exp[33:32], exp[31:16], exp[15:0]);
    end
  endtask

  function automatic logic [35:0] dut_out();
    return {u_if.al_locked, u_if.al_valid, u_if.al_ctrl, u_if.al_data,
            u_if.al_err_cnt};
  endfunction

  localparam logic [15:0] W  = 16'h50BC;   // low-lane comma word
  localparam logic [15:0] HC = 16'hBC12;   // high-lane comma word
  localparam logic [15:0] HF = 16'h3456;   // filler after HC

  initial begin
    rst_n              = 1'b0;
    u_if.rx_ctrl       = 2'b00;
    u_if.rx_data       = 16'h0000;
    u_if.rx_disperr    = 2'b00;
    u_if.rx_notintable = 2'b00;

    // rst, ctrl, data, disperr, notintable | locked, ctrl_o, data_o, err
    // Reset state
    tbl.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    // Low-lane lock after four commas
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        0));
    tbl.push_back(mk(1, 2'b00, 16'h1234, 2'b00, 2'b00, 1, 2'b00, 16'h1234, 0));
    // Four consecutive errors drop lock on the fourth
    tbl.push_back(mk(1, 2'b00, 16'h1111, 2'b01, 2'b00, 1, 2'b00, 16'h1111, 1));
    tbl.push_back(mk(1, 2'b00, 16'h2222, 2'b01, 2'b00, 1, 2'b00, 16'h2222, 2));
    tbl.push_back(mk(1, 2'b00, 16'h3333, 2'b01, 2'b00, 1, 2'b00, 16'h3333, 3));
    tbl.push_back(mk(1, 2'b00, 16'h4444, 2'b01, 2'b00, 0, 2'b00, 16'h0000, 4));
    // Relock, then three errors + clean word keeps lock
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 4));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 4));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 4));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        4));
    tbl.push_back(mk(1, 2'b00, 16'h1111, 2'b00, 2'b10, 1, 2'b00, 16'h1111, 5));
    tbl.push_back(mk(1, 2'b00, 16'h2222, 2'b10, 2'b00, 1, 2'b00, 16'h2222, 6));
    tbl.push_back(mk(1, 2'b00, 16'h3333, 2'b00, 2'b01, 1, 2'b00, 16'h3333, 7));
    tbl.push_back(mk(1, 2'b00, 16'h4444, 2'b00, 2'b00, 1, 2'b00, 16'h4444, 7));
    tbl.push_back(mk(1, 2'b00, 16'h5555, 2'b01, 2'b00, 1, 2'b00, 16'h5555, 8));
    // Reset mid-lock, then relock
    tbl.push_back(mk(0, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        0));
    // VERIFY aborted by a high-lane comma; needs four fresh commas
    tbl.push_back(mk(0, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        0));
    // High-lane comma stream, offset 1
    tbl.push_back(mk(0, 2'b00, HF,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b00, HF,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b00, HF,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b00, HF,       2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 1, 2'b00, 16'h1234, 0));
    tbl.push_back(mk(1, 2'b00, HF,       2'b00, 2'b00, 1, 2'b01, 16'h56BC, 0));
    tbl.push_back(mk(1, 2'b10, HC,       2'b00, 2'b00, 1, 2'b00, 16'h1234, 0));
    // Low-lane comma while locked on high lane: bad word, not an error count
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b11, 16'hBCBC, 0));
    tbl.push_back(mk(1, 2'b00, HF,       2'b00, 2'b00, 1, 2'b00, 16'h5650, 0));
    // Commas in both lanes resolve to the low lane
    tbl.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b11, 16'hBCBC, 2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 0, 2'b00, 16'h0000, 0));
    tbl.push_back(mk(1, 2'b01, W,        2'b00, 2'b00, 1, 2'b01, W,        0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].ctrl, tbl[i].data, tbl[i].de, tbl[i].nit);
      check($sformatf("row%0d", i), dut_out(),
            {tbl[i].lk, tbl[i].lk, tbl[i].co, tbl[i].dout, exp_err(tbl[i].err)});
    end

    // 100 errored words while locked, a clean word after every third error
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'b00, 16'hA5A5, 2'b01, 2'b00);
      if ((i % 3) == 2) drive(1'b1, 2'b01, W, 2'b00, 2'b00);
    end
    check("err100_main", {u_if.al_locked, u_if.al_valid, 34'd0, u_if.al_err_cnt},
          {1'b1, 1'b1, 34'd0, exp_err(16'd100)});

`ifdef GTX_RX_ALIGN_ERR_CNT_EN
    check("err100_sat", {sat_locked, sat_valid, 34'd0, sat_err},
          {1'b1, 1'b1, 34'd0, 16'd100});
    // Drive the tolerant instance past 65535 errors while it stays locked.
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 2'b00, 16'hA5A5, 2'b00, 2'b10);
      if ((i % 14) == 13) drive(1'b1, 2'b01, W, 2'b00, 2'b00);
    end
    check("err_saturate", {sat_locked, sat_valid, 34'd0, sat_err},
          {1'b1, 1'b1, 34'd0, 16'hFFFF});
    // Reset clears the saturated counter on the next edge.
    drive(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
    check("err_reset", {sat_locked, sat_valid, 34'd0, sat_err},
          {1'b0, 1'b0, 34'd0, 16'h0000});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_gtx_rx_align
`default_nettype wire

// File: doc/gtx_rx_align.md
GTX_RX_ALIGN -- requirements
Module: gtx_rx_align

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, K28.5 comma byte value.
REQ-002 SHALL have parameter LOCK_CNT, default 4, consecutive same-offset commas needed to lock (range 1..15).
REQ-003 SHALL have parameter LOSS_CNT, default 4, consecutive errored words needed to drop lock (range 1..15).
REQ-004 SHALL have port clk_i, input, 1, rxusrclk2 domain clock; single clock for the whole block.
REQ-005 SHALL have port rst_n_i, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port ctrl_i, input, 2, rxcharisk from transceiver, bit n qualifies byte n.
REQ-007 SHALL have port data_i, input, 16, rxdata from transceiver.
REQ-008 SHALL have port disperr_i, input, 2, per-byte disparity error.
REQ-009 SHALL have port notintable_i, input, 2, per-byte not-in-table error.
REQ-010 SHALL have port ctrl_o, output, 2, aligned charisk to downstream receive stage.
REQ-011 SHALL have port data_o, output, 16, aligned data to downstream receive stage.
REQ-012 SHALL have port valid_o, output, 1, data_o/ctrl_o valid (lock held).
REQ-013 SHALL have port locked_o, output, 1, alignment FSM in LOCKED.
REQ-014 SHALL have port err_cnt_o, output, 16, saturating errored-word count.

Function
REQ-015 Comma detect SHALL be: low hit = ctrl_i[0] and data_i[7:0]==COMMA; high hit = ctrl_i[1] and data_i[15:8]==COMMA; both hits in one word SHALL resolve to low (offset 0).
REQ-016 Errored word SHALL be any bit of disperr_i or notintable_i set.
REQ-017 Block SHALL register previous input word every cycle (prev_data, prev_ctrl).
REQ-018 Offset 0: data_o/ctrl_o SHALL equal input word of previous cycle (latency 1).
REQ-019 Offset 1: data_o SHALL be {data_i[7:0], prev_data[15:8]}, ctrl_o {ctrl_i[0], prev_ctrl[1]}, registered (latency 1 on high byte, 2 on low).
REQ-020 FSM states SHALL be HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-021 HUNT: on comma hit, latch offset, good count=1, go VERIFY (LOCKED directly if LOCK_CNT==1); otherwise stay.
REQ-022 VERIFY: same-offset comma increments good count, reaching LOCK_CNT goes LOCKED; other-offset comma or errored word goes HUNT; non-comma clean word holds.
REQ-023 LOCKED: errored word or other-offset comma increments bad count; clean word clears it; bad count reaching LOSS_CNT goes HUNT in that cycle.
REQ-024 valid_o and locked_o SHALL be high only while state is LOCKED, aligned with data_o (valid_o registered with data).
REQ-025 While not LOCKED, data_o and ctrl_o SHALL be driven zero.
REQ-026 err_cnt_o SHALL increment by 1 per errored word in LOCKED, saturate at 16'hFFFF, never wrap.
REQ-027 Offset latched in VERIFY/LOCKED SHALL NOT change until return to HUNT.

Reset
REQ-028 rst_n_i low at a clock edge SHALL force state HUNT, offset 0, all counters 0, prev regs 0, data_o 0, ctrl_o 0, valid_o 0, locked_o 0, err_cnt_o 0.
REQ-029 Reset mid-lock SHALL drop valid_o the next edge; err_cnt_o SHALL clear.

Configuration
REQ-030 Macro GTX_RX_ALIGN_ERR_CNT_EN defined: err_cnt_o implemented per REQ-026.
REQ-031 Macro undefined: no counter logic; err_cnt_o tied 16'h0000; all other behaviour identical.

Structure
REQ-032 Shared package gtx_pkg SHALL hold state enum (HUNT/VERIFY/LOCKED), K28_5 constant 8'hBC, error-count width constant.
REQ-033 Single module; no sub-module.

Verification
REQ-034 Four words 16'h50BC ctrl 2'b01 -> locked_o 1 after 4th word edge, next data_o 16'h50BC ctrl_o 2'b01 valid_o 1.
REQ-035 Stream with comma in high byte (16'hBC12 ctrl 2'b10, then 16'h3456) x4 -> locked, data_o 16'h56BC, ctrl_o 2'b01.
REQ-036 Locked, then 4 consecutive words disperr_i 2'b01 -> err_cnt_o 4, locked_o 0, valid_o 0, data_o 0; 3 errors then clean word -> stays locked.
REQ-037 VERIFY after 2 low commas, then high-only comma -> back to HUNT, locked_o stays 0.
REQ-038 Locked, rst_n_i low one cycle -> all outputs 0 next edge, relock after 4 commas.
REQ-039 Macro undefined, 100 errored words while locked -> err_cnt_o stays 0; macro defined, 70000 errors -> err_cnt_o 16'hFFFF.
